plic_multi_target: RTL
======================

Name: plic_multi_target

Overview:
Parametrised successor to the single-context PLIC target. Combines per-source interrupt gateways (level or edge mode), per-target priority/threshold arbitration for TGT_CNT targets (hart contexts), and the claim/complete handshake with in-service tracking. Sits between the peripheral interrupt lines and the PLIC register slave. The register slave supplies enables, priorities and thresholds, and issues claim/complete strobes.

Parameters:
SRC_CNT, 32, number of interrupt sources; source bit i carries ID i+1, ID 0 means "none"
SRC_W, 6, ID width; must satisfy 2^SRC_W > SRC_CNT
PRIO_W, 3, priority/threshold width
TGT_CNT, 2, number of targets
EDGE_MASK, '0, SRC_CNT-bit mask; bit i=1 makes source i edge-triggered, 0 makes it level-triggered

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
irq_src_i  input  SRC_CNT  raw interrupt lines, synchronous to clk
ie_i  input  TGT_CNT x SRC_CNT  per-target enable
prio_i  input  SRC_CNT x PRIO_W  per-source priority; 0 = never interrupts
th_i  input  TGT_CNT x PRIO_W  per-target threshold
claim_req_i  input  TGT_CNT  one-cycle claim strobe per target
claim_valid_o  output  TGT_CNT  claim response strobe
claim_id_o  output  TGT_CNT x SRC_W  claimed ID; 0 = nothing claimed
complete_req_i  input  TGT_CNT  one-cycle complete strobe
complete_id_i  input  TGT_CNT x SRC_W  ID being completed
irq_req_o  output  TGT_CNT  interrupt request to target
irq_idx_o  output  TGT_CNT x SRC_W  best pending ID per target
pending_o  output  SRC_CNT  pending register, for the pending-array read

Behaviour:
- Reset (rst=1, asynchronous): pending, in_service, edge-history, irq_req_o, irq_idx_o, claim_valid_o and claim_id_o all go to 0.
- Gateway, level source i: pending[i] is set at the next edge when irq_src_i[i]=1, pending[i]=0 and in_service[i]=0.
- Gateway, edge source i: a rising edge is irq_src_i[i]=1 with prev[i]=0, where prev is registered every cycle. On a rising edge, pending[i] is set if pending[i]=0 and in_service[i]=0. Otherwise the edge is dropped (no edge counting).
- A source held high across reset release counts as one rising edge, because prev resets to 0.
- Arbitration, per target t, combinational on registered state:
  - Candidates are sources with pending & ie_i[t] and prio_i > th_i[t] (strictly greater).
  - The winner is the highest priority; ties go to the lowest ID.
  - irq_idx_o[t] and irq_req_o[t] are registered. Latency: pending change to output update is 1 cycle, so irq_src_i to irq_req_o is 2 cycles.
  - With no candidate, irq_req_o[t]=0 and irq_idx_o[t]=0.
- Claim, cycle N with claim_req_i[t]=1: let id = irq_idx_o[t].
  - If id != 0, pending[id-1]=1, and no lower-index target claims the same id in cycle N: the claim is granted. At edge N+1, pending[id-1] clears, in_service[id-1] sets, and claim_id_o[t]=id.
  - Otherwise claim_id_o[t]=0.
  - claim_valid_o[t]=1 for exactly cycle N+1 in both cases. claim_id_o holds its value until the next claim.
- Simultaneous claims of the same id by several targets: the lowest target index wins and the others receive 0.
- Gateway set and claim of the same source in the same cycle: the claim takes priority and pending ends at 0.
- Complete, cycle N with complete_req_i[t]=1 and id=complete_id_i[t]:
  - If 1 <= id <= SRC_CNT and in_service[id-1]=1, in_service clears at N+1.
  - Otherwise the complete is ignored silently.
  - A complete is not checked against the claiming target.
- After a complete, a level source still high re-pends at N+2 (the gateway sees in_service=0 at N+1).
- A claim and a complete in the same cycle on different IDs are processed independently. A claim and a complete on the same ID cannot be granted together, because pending and in_service are mutually exclusive.
- Invariant: pending[i] & in_service[i] is never 1.
- Changes to prio_i, th_i or ie_i take effect on irq_*_o one cycle later. Lowering a threshold or priority never drops an in-service interrupt.

Test Plan:
- Reset, then level src 4 (ID 5) high with prio=3, th[0]=1, ie[0][4]=1 -> pending_o[4]=1 at cycle 1; irq_req_o[0]=1 and irq_idx_o[0]=5 at cycle 2; target 1 (ie=0) stays 0.
- IDs 3 and 7 pending with equal prio=2, then ID 7 raised to prio=5 -> irq_idx_o=3 first, then 7 one cycle after the prio change; setting th=5 -> irq_req_o=0 and irq_idx_o=0.
- Both targets enabled for ID 5 and claim in the same cycle -> claim_id_o[0]=5, claim_id_o[1]=0, both claim_valid_o pulse; pending_o[4]=0; irq_req_o of both drop the following cycle.
- Level ID 5 still high after the claim, complete_id=5 -> no re-pend while in service; pending_o[4]=1 two cycles after the complete. complete_id=9 with 9 not in service, and complete_id=0 -> no state change.
- Edge source (EDGE_MASK bit 2, ID 3): three pulses, the second arriving while in service -> exactly two claims return 3; the dropped edge leaves pending_o[2]=0.
- Assert rst mid-service (ID 5 in service, ID 3 pending) -> all outputs 0 immediately; after release, level ID 5 still high re-pends within 1 cycle.

Source files
------------

// File: rtl/plic_multi_target.sv
// Multi-context PLIC core: level/edge gateways per source, priority/threshold
// arbitration per target, and claim/complete handling with in-service tracking.
module plic_multi_target #(
   parameter int                 SRC_CNT   = 32,
   parameter int                 SRC_W     = 6,
   parameter int                 PRIO_W    = 3,
   parameter int                 TGT_CNT   = 2,
   parameter logic [SRC_CNT-1:0] EDGE_MASK = '0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [SRC_CNT-1:0]              irq_src_i,
   input  logic [TGT_CNT-1:0][SRC_CNT-1:0] ie_i,
   input  logic [SRC_CNT-1:0][PRIO_W-1:0]  prio_i,
   input  logic [TGT_CNT-1:0][PRIO_W-1:0]  th_i,
   input  logic [TGT_CNT-1:0]              claim_req_i,
   output logic [TGT_CNT-1:0]              claim_valid_o,
   output logic [TGT_CNT-1:0][SRC_W-1:0]   claim_id_o,
   input  logic [TGT_CNT-1:0]              complete_req_i,
   input  logic [TGT_CNT-1:0][SRC_W-1:0]   complete_id_i,
   output logic [TGT_CNT-1:0]              irq_req_o,
   output logic [TGT_CNT-1:0][SRC_W-1:0]   irq_idx_o,
   output logic [SRC_CNT-1:0]              pending_o
);

   logic [SRC_CNT-1:0]            r_pending;
   logic [SRC_CNT-1:0]            r_in_service;
   logic [SRC_CNT-1:0]            r_prev;
   logic [TGT_CNT-1:0]            r_irq_req;
   logic [TGT_CNT-1:0][SRC_W-1:0] r_irq_idx;
   logic [TGT_CNT-1:0]            r_claim_valid;
   logic [TGT_CNT-1:0][SRC_W-1:0] r_claim_id;

   logic [SRC_CNT-1:0]            w_gw_set;
   logic [SRC_CNT-1:0]            w_claim_clr;
   logic [SRC_CNT-1:0]            w_cmpl_clr;
   logic [TGT_CNT-1:0]            w_grant;
   logic [TGT_CNT-1:0]            w_best_req;
   logic [TGT_CNT-1:0][SRC_W-1:0] w_best_id;

   // Edge sources only fire when the previous sample was low; busy sources drop the request.
   assign w_gw_set = irq_src_i & ~(r_prev & EDGE_MASK) & ~r_pending & ~r_in_service;

   // Per-target winner: strictly above threshold, highest priority, lowest ID on ties.
   always_comb begin
      logic [PRIO_W-1:0] v_prio;
      w_best_id  = '0;
      w_best_req = '0;
      v_prio     = '0;
      for (int t = 0; t < TGT_CNT; t++) begin
         v_prio = th_i[t];
         for (int i = 0; i < SRC_CNT; i++) begin
            if (r_pending[i] && ie_i[t][i] && (prio_i[i] > v_prio)) begin
               v_prio       = prio_i[i];
               w_best_id[t] = SRC_W'(i + 1);
            end else begin
               v_prio       = v_prio;
            end
         end
         w_best_req[t] = (w_best_id[t] != {SRC_W{1'b0}});
      end
   end

   // Claim grants: a lower-index target claiming the same ID in the same cycle blocks this one.
   always_comb begin
      logic v_blk;
      w_grant     = '0;
      w_claim_clr = '0;
      v_blk       = 1'b0;
      for (int t = 0; t < TGT_CNT; t++) begin
         v_blk = 1'b0;
         for (int u = 0; u < t; u++) begin
            if (claim_req_i[u] && (r_irq_idx[u] == r_irq_idx[t])) begin
               v_blk = 1'b1;
            end else begin
               v_blk = v_blk;
            end
         end
         for (int i = 0; i < SRC_CNT; i++) begin
            if (claim_req_i[t] && !v_blk && (r_irq_idx[t] == SRC_W'(i + 1)) && r_pending[i]) begin
               w_grant[t]     = 1'b1;
               w_claim_clr[i] = 1'b1;
            end else begin
               w_claim_clr[i] = w_claim_clr[i];
            end
         end
      end
   end

   // Completes clear in-service only for valid IDs that are actually in service.
   always_comb begin
      w_cmpl_clr = '0;
      for (int t = 0; t < TGT_CNT; t++) begin
         for (int i = 0; i < SRC_CNT; i++) begin
            if (complete_req_i[t] && (complete_id_i[t] == SRC_W'(i + 1)) && r_in_service[i]) begin
               w_cmpl_clr[i] = 1'b1;
            end else begin
               w_cmpl_clr[i] = w_cmpl_clr[i];
            end
         end
      end
   end

   // Gateway and in-service state; claims are only granted on pending sources so set/clear never collide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev       <= '0;
         r_pending    <= '0;
         r_in_service <= '0;
      end else begin
         r_prev       <= irq_src_i;
         r_pending    <= (r_pending | w_gw_set) & ~w_claim_clr;
         r_in_service <= (r_in_service | w_claim_clr) & ~w_cmpl_clr;
      end
   end

   // Registered arbitration results and claim responses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_irq_req     <= '0;
         r_irq_idx     <= '0;
         r_claim_valid <= '0;
         r_claim_id    <= '0;
      end else begin
         r_irq_req     <= w_best_req;
         r_irq_idx     <= w_best_id;
         r_claim_valid <= claim_req_i;
         for (int t = 0; t < TGT_CNT; t++) begin
            if (claim_req_i[t]) begin
               r_claim_id[t] <= w_grant[t] ? r_irq_idx[t] : {SRC_W{1'b0}};
            end
         end
      end
   end

   assign claim_valid_o = r_claim_valid;
   assign claim_id_o    = r_claim_id;
   assign irq_req_o     = r_irq_req;
   assign irq_idx_o     = r_irq_idx;
   assign pending_o     = r_pending;

endmodule
